tlul_host_arb: RTL



---
 rtl/tlul_host_arb_if.sv | 49 ++++
 rtl/tlul_host_arb.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tlul_host_arb_if.sv
// TL-UL host arbiter bus types and interface: NumHosts host ports plus one device port.
// The interface carries the grant index, outstanding count and orphan-response error.
package tlul_host_arb_pkg;
  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

interface tlul_host_arb_if #(
  parameter int NumHosts = 3,
  parameter int MaxOut   = 4
);
  import tlul_host_arb_pkg::*;
  localparam int IdxW = $clog2(NumHosts);
  localparam int CntW = $clog2(MaxOut + 1);

  tl_h2d_t [NumHosts-1:0] tl_h_i;
  tl_d2h_t [NumHosts-1:0] tl_h_o;
  tl_h2d_t                tl_d_o;
  tl_d2h_t                tl_d_i;
  logic [IdxW-1:0]        gnt_idx_o;
  logic [CntW-1:0]        outstanding_o;
  logic                   err_o;

  modport master (output tl_h_i, tl_d_i,
                  input  tl_h_o, tl_d_o, gnt_idx_o, outstanding_o, err_o);
  modport slave  (input  tl_h_i, tl_d_i,
                  output tl_h_o, tl_d_o, gnt_idx_o, outstanding_o, err_o);
endinterface

// File: rtl/tlul_host_arb.sv
// Shares one TL-UL device port among NumHosts hosts; in-order host-index FIFO routes D responses.
// Define TLUL_ARB_FIXED_PRIO_EN for fixed priority (host 0 highest) instead of round-robin.
module tlul_host_arb_port
  import tlul_host_arb_pkg::*;
#(
  parameter int              IdxW = 2,
  parameter logic [IdxW-1:0] Idx  = '0
) (
  input  logic [IdxW-1:0] gnt,
  input  logic [IdxW-1:0] head,
  input  logic            a_open,
  input  logic            d_open,
  input  tl_d2h_t         dev_rsp,
  output tl_d2h_t         rsp
);
  always_comb begin
    rsp         = dev_rsp;
    rsp.a_ready = a_open & (gnt == Idx);
    rsp.d_valid = d_open & (head == Idx);
  end
endmodule

module tlul_host_arb
  import tlul_host_arb_pkg::*;
#(
  parameter int NumHosts = 3,
  parameter int MaxOut   = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  tlul_host_arb_if.slave bus
);
  localparam int IdxW = $clog2(NumHosts);
  localparam int CntW = $clog2(MaxOut + 1);
  localparam int PtrW = (MaxOut > 1) ? $clog2(MaxOut) : 1;

  logic [IdxW-1:0] gnt, gnt_q, arb_idx, lock_idx_q, head;
  logic            lock_q, full, empty, a_go, hs, pop;
  logic [CntW-1:0] cnt_q;
  logic [PtrW-1:0] wr_q, rd_q;
  logic [IdxW-1:0] fifo_q [MaxOut];
  tl_h2d_t         req;
  tl_d2h_t         h_rsp [NumHosts];
`ifndef TLUL_ARB_FIXED_PRIO_EN
  logic [IdxW-1:0] last_q;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOut - 1)) ? '0 : p + 1'b1;
  endfunction

  // With no requester the previous grant is held rather than snapping to a default.
  always_comb begin
    arb_idx = gnt_q;
`ifdef TLUL_ARB_FIXED_PRIO_EN
    for (int i = NumHosts - 1; i >= 0; i--)
      if (bus.tl_h_i[i].a_valid) arb_idx = IdxW'(i);
`else
    begin
      logic            hit;
      logic [IdxW-1:0] h;
      hit = 1'b0;
      for (int k = 1; k <= NumHosts; k++) begin
        h = IdxW'((int'(last_q) + k) % NumHosts);
        if (!hit && bus.tl_h_i[h].a_valid) begin
          arb_idx = h;
          hit     = 1'b1;
        end
      end
    end
`endif
  end

  assign gnt   = lock_q ? lock_idx_q : arb_idx;
  assign req   = bus.tl_h_i[gnt];
  assign full  = (cnt_q == CntW'(MaxOut));
  assign empty = (cnt_q == '0);
  assign head  = fifo_q[rd_q];
  assign a_go  = req.a_valid & ~full;
  assign hs    = a_go & bus.tl_d_i.a_ready;
  assign pop   = bus.tl_d_i.d_valid & ~empty & bus.tl_h_i[head].d_ready;

  // Empty FIFO keeps d_ready high so stray responses drain instead of stalling the device.
  always_comb begin
    bus.tl_d_o         = req;
    bus.tl_d_o.a_valid = a_go;
    bus.tl_d_o.d_ready = empty ? 1'b1 : bus.tl_h_i[head].d_ready;
  end

  assign bus.gnt_idx_o     = gnt;
  assign bus.outstanding_o = cnt_q;
  assign bus.err_o         = bus.tl_d_i.d_valid & empty;

  for (genvar i = 0; i < NumHosts; i++) begin : g_host
    tlul_host_arb_port #(.IdxW(IdxW), .Idx(IdxW'(i))) u_port (
      .gnt     (gnt),
      .head    (head),
      .a_open  (~full & bus.tl_d_i.a_ready),
      .d_open  (bus.tl_d_i.d_valid & ~empty),
      .dev_rsp (bus.tl_d_i),
      .rsp     (h_rsp[i])
    );
  end

  always_comb
    for (int i = 0; i < NumHosts; i++) bus.tl_h_o[i] = h_rsp[i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q      <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < MaxOut; i++) fifo_q[i] <= '0;
`ifndef TLUL_ARB_FIXED_PRIO_EN
      last_q     <= IdxW'(NumHosts - 1);
`endif
    end else begin
      gnt_q <= gnt;
      // Hold the grant on a stalled request so the device sees stable A fields.
      if (a_go && !bus.tl_d_i.a_ready) begin
        lock_q     <= 1'b1;
        lock_idx_q <= gnt;
      end else if (hs || (lock_q && !req.a_valid)) begin
        lock_q <= 1'b0;
      end
      if (hs) begin
        fifo_q[wr_q] <= gnt;
        wr_q         <= ptr_inc(wr_q);
`ifndef TLUL_ARB_FIXED_PRIO_EN
        last_q       <= gnt;
`endif
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      case ({hs, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule
